// File: rtl/int_atom_pkg.sv
// Shared layout of the packed integer-atom bus and the field tags.
// Used by int_field_unpacker and int_field_extract.
package int_atom_pkg;

  localparam int BYTE_W     = 8;
  localparam int SHORTINT_W = 16;
  localparam int INT_W      = 32;
  localparam int INTEGER_W  = 32;
  localparam int LONGINT_W  = 64;

  localparam int E_LSB  = 0;
  localparam int D_LSB  = 8;
  localparam int C_LSB  = 72;
  localparam int B_LSB  = 88;
  localparam int A_LSB  = 120;
  localparam int PACK_W = 152;

  typedef enum logic [2:0] {
    TAG_A = 3'd0,
    TAG_B = 3'd1,
    TAG_C = 3'd2,
    TAG_D = 3'd3,
    TAG_E = 3'd4
  } field_tag_e;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/int_field_extract.sv
// Selects one field of the captured word and widens it to OUT_W.
// UNPACK_SIGN_EXT_EN selects sign extension; otherwise zero extension.
module int_field_extract
  import int_atom_pkg::*;
#(
  parameter int OUT_W = 64
) (
  input  logic [PACK_W-1:0] cap,
  input  logic [2:0]        tag,
  output logic [OUT_W-1:0]  data
);

`ifdef UNPACK_SIGN_EXT_EN
  localparam logic SEXT = 1'b1;
`else
  localparam logic SEXT = 1'b0;
`endif

  logic [LONGINT_W-1:0] w;

  always_comb begin
    w = '0;
    unique case (field_tag_e'(tag))
      TAG_A: w = {{(LONGINT_W-INTEGER_W){SEXT & cap[A_LSB+INTEGER_W-1]}},
                  cap[A_LSB +: INTEGER_W]};
      TAG_B: w = {{(LONGINT_W-INT_W){SEXT & cap[B_LSB+INT_W-1]}},
                  cap[B_LSB +: INT_W]};
      TAG_C: w = {{(LONGINT_W-SHORTINT_W){SEXT & cap[C_LSB+SHORTINT_W-1]}},
                  cap[C_LSB +: SHORTINT_W]};
      TAG_D: w = cap[D_LSB +: LONGINT_W];
      TAG_E: w = {{(LONGINT_W-BYTE_W){SEXT & cap[E_LSB+BYTE_W-1]}},
                  cap[E_LSB +: BYTE_W]};
      default: w = '0;
    endcase
    // The 64-bit intermediate is widened again when OUT_W > 64
    data = {OUT_W{SEXT & w[LONGINT_W-1]}};
    data[LONGINT_W-1:0] = w;
  end

endmodule

// File: rtl/int_field_unpacker.sv
// Captures a packed {a,b,c,d,e} word and streams the fields one per beat.
// Extension mode is set by UNPACK_SIGN_EXT_EN inside int_field_extract.
module int_field_unpacker
  import int_atom_pkg::*;
#(
  parameter int IN_W  = 1024,
  parameter int OUT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [2:0]       out_tag,
  output logic             out_last
);

  state_e            state;
  field_tag_e        tag;
  logic              valid;
  logic              last;
  logic [PACK_W-1:0] cap;
  logic              unused_hi;

  assign unused_hi = ^in_data[IN_W-1:PACK_W];

  assign in_ready  = (state == IDLE) || (valid && out_ready && last);
  assign out_valid = valid;
  assign out_tag   = tag;
  assign out_last  = last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tag   <= TAG_A;
      valid <= 1'b0;
      last  <= 1'b0;
      cap   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cap   <= in_data[PACK_W-1:0];
            tag   <= TAG_A;
            last  <= 1'b0;
            valid <= 1'b1;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (!last) begin
              tag  <= field_tag_e'(tag + 3'd1);
              last <= (tag == TAG_D);
            end else if (in_valid) begin
              // Back-to-back word: restart without a bubble
              cap  <= in_data[PACK_W-1:0];
              tag  <= TAG_A;
              last <= 1'b0;
            end else begin
              state <= IDLE;
              valid <= 1'b0;
              tag   <= TAG_A;
              last  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  int_field_extract #(
    .OUT_W(OUT_W)
  ) u_extract (
    .cap  (cap),
    .tag  (tag),
    .data (out_data)
  );

endmodule

// File: tb/tb_int_field_unpacker.sv
// Directed bench for int_field_unpacker; expectations follow UNPACK_SIGN_EXT_EN.
module tb_int_field_unpacker;

  localparam int IN_W  = 1024;
  localparam int OUT_W = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [2:0]       out_tag;
  logic             out_last;

  int n_vec = 0;
  int n_err = 0;

  logic [151:0] w_gold;
  logic [151:0] w_small;
  logic [871:0] junk;
  logic [63:0]  exp_g [5];
  logic [63:0]  exp_s [5];

  int_field_unpacker #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", name, obs, expv);
    end
  endtask

  task automatic beat(input int k, input bit gold);
    logic [63:0] e;
    e = gold ? exp_g[k] : exp_s[k];
    chk($sformatf("valid%0d", k), 64'(out_valid), 64'd1);
    chk($sformatf("tag%0d", k), 64'(out_tag), 64'(k));
    chk($sformatf("data%0d", k), out_data, e);
    chk($sformatf("last%0d", k), 64'(out_last), 64'(k == 4));
  endtask

  task automatic run_word(input logic [IN_W-1:0] w, input bit gold);
    in_data  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      beat(k, gold);
      step();
    end
    chk("idle_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    w_gold  = {32'hFFFFFFFF, 32'hFFFFFFFE, 16'hFFFD,
               64'hFFFFFFFFFFFFFFFC, 8'hFB};
    w_small = {32'd1, 32'd2, 16'd3, 64'd4, 8'd5};
    junk    = {109{8'hA5}};
`ifdef UNPACK_SIGN_EXT_EN
    exp_g = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE,
              64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFC,
              64'hFFFFFFFFFFFFFFFB};
`else
    exp_g = '{64'h00000000FFFFFFFF, 64'h00000000FFFFFFFE,
              64'h000000000000FFFD, 64'hFFFFFFFFFFFFFFFC,
              64'h00000000000000FB};
`endif
    exp_s = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    step();

    // Single gold word, ready held high
    run_word({872'd0, w_gold}, 1'b1);

    // Back-to-back words with in_valid held
    in_data  = {872'd0, w_gold};
    in_valid = 1'b1;
    step();
    in_data = {872'd0, w_small};
    for (int k = 0; k < 5; k++) begin
      beat(k, 1'b1);
      chk($sformatf("b2b_ready%0d", k), 64'(in_ready), 64'(k == 4));
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      beat(k, 1'b0);
      step();
    end
    chk("b2b_idle", 64'(out_valid), 64'd0);

    // Stall on tag 2 for two extra cycles
    in_data  = {872'd0, w_gold};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    beat(0, 1'b1);
    step();
    beat(1, 1'b1);
    step();
    beat(2, 1'b1);
    out_ready = 1'b0;
    step();
    beat(2, 1'b1);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    step();
    beat(2, 1'b1);
    out_ready = 1'b1;
    step();
    beat(3, 1'b1);
    step();
    beat(4, 1'b1);
    step();
    chk("stall_idle", 64'(out_valid), 64'd0);

    // Asynchronous reset in the middle of a word
    in_data  = {872'd0, w_gold};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    beat(0, 1'b1);
    step();
    beat(1, 1'b1);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_tag", 64'(out_tag), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    run_word({872'd0, w_small}, 1'b0);

    // Garbage above bit 151 must not matter
    run_word({junk, w_gold}, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
